// File: rtl/sddr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sddr_pkg: shared SDDR data-path types, burst sizing and beat slicing.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package sddr_pkg;

  typedef enum logic [0:0] {
    CAP_IDLE   = 1'b0,
    CAP_ACTIVE = 1'b1
  } cap_state_e;

  // Two beats (rise/fall) move per clock, so a burst spans half its length in cycles.
  function automatic int half_burst_length(input int burst_length);
    return burst_length / 2;
  endfunction

  function automatic int beat_lsb(input int beat, input int data_bits);
    return beat * data_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sddr_read_capture_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sddr_read_capture_if: read-issue inputs and response port bundle.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface sddr_read_capture_if #(
  parameter int DATA_BITS    = 16,
  parameter int BURST_LENGTH = 8,
  parameter int TAG_BITS     = 4
);
  logic                              read_issue_i;
  logic [TAG_BITS-1:0]               read_tag_i;
  logic [15:0]                       cas_latency_i;
  logic [1:0][DATA_BITS-1:0]         ddr3_dq_i;
  logic                              error_clear_i;
  logic                              data_rsp_ready_o;
  logic [BURST_LENGTH*DATA_BITS-1:0] data_rsp_data_o;
  logic [TAG_BITS-1:0]               data_rsp_tag_o;
  logic                              capture_busy_o;
  logic                              protocol_error_o;

  modport master (
    output read_issue_i, read_tag_i, cas_latency_i, ddr3_dq_i, error_clear_i,
    input  data_rsp_ready_o, data_rsp_data_o, data_rsp_tag_o, capture_busy_o,
    input  protocol_error_o
  );

  modport slave (
    input  read_issue_i, read_tag_i, cas_latency_i, ddr3_dq_i, error_clear_i,
    output data_rsp_ready_o, data_rsp_data_o, data_rsp_tag_o, capture_busy_o,
    output protocol_error_o
  );
endinterface
`default_nettype wire

// File: rtl/sddr_read_latency_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sddr_read_latency_pipe: pending-read countdown array, window checks.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sddr_read_latency_pipe
  import sddr_pkg::*;
#(
  parameter int BURST_LENGTH    = 8,
  parameter int MAX_CAS_LATENCY = 16,
  parameter int TAG_BITS        = 4
) (
  input  logic                cpu_clock_i,
  input  logic                ctrl_reset_i,
  input  logic                issue_i,
  input  logic [TAG_BITS-1:0] tag_i,
  input  logic [15:0]         cas_latency_i,
  output logic                accept_o,
  output logic                range_err_o,
  output logic                overlap_err_o,
  output logic                start_o,
  output logic [TAG_BITS-1:0] start_tag_o,
  output logic                pending_o
);
  localparam int          HALF   = half_burst_length(BURST_LENGTH);
  localparam int          DEPTH  = MAX_CAS_LATENCY;
  localparam int          CNT_W  = $clog2(MAX_CAS_LATENCY + 1);
  localparam int          MIN_W  = $clog2(MAX_CAS_LATENCY + HALF + 1);
  localparam logic [15:0] CL_MAX = 16'(MAX_CAS_LATENCY);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [DEPTH];
  logic [TAG_BITS-1:0] tag_d [DEPTH];
  logic [CNT_W-1:0]    cnt_q [DEPTH];
  logic [CNT_W-1:0]    cnt_d [DEPTH];
  logic [MIN_W-1:0]    min_cl_q, min_cl_d;
  logic                range_ok;
  logic                fits;
  logic                placed;

  // min_cl is the smallest CL that lands a new window at or after the end of
  // the last scheduled one; this also blocks short-CL reads from overtaking.
  always_comb begin
    range_ok      = (cas_latency_i != 16'd0) && (cas_latency_i <= CL_MAX);
    fits          = 32'(min_cl_q) <= 32'(cas_latency_i);
    accept_o      = issue_i && !ctrl_reset_i && range_ok && fits;
    range_err_o   = issue_i && !ctrl_reset_i && !range_ok;
    overlap_err_o = issue_i && !ctrl_reset_i && range_ok && !fits;

    min_cl_d = (min_cl_q == '0) ? '0 : min_cl_q - MIN_W'(1);
    if (accept_o) begin
      min_cl_d = MIN_W'(cas_latency_i) + MIN_W'(HALF - 1);
    end

    start_o     = 1'b0;
    start_tag_o = '0;
    placed      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      cnt_d[i]   = cnt_q[i];
      if (valid_q[i]) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          start_o     = 1'b1;
          start_tag_o = tag_q[i];
          valid_d[i]  = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end

    // CL=1 must start capture next cycle, so it bypasses the array entirely.
    if (accept_o && (cas_latency_i == 16'd1)) begin
      start_o     = 1'b1;
      start_tag_o = tag_i;
    end else if (accept_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!valid_d[i] && !placed) begin
          valid_d[i] = 1'b1;
          tag_d[i]   = tag_i;
          cnt_d[i]   = CNT_W'(cas_latency_i - 16'd1);
          placed     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (ctrl_reset_i) begin
      valid_q  <= '0;
      min_cl_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      min_cl_q <= min_cl_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pending_o = |valid_q;

endmodule
`default_nettype wire

// File: rtl/sddr_read_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sddr_read_capture: CAS-latency aligned DDR read burst capture/assembly.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sddr_read_capture
  import sddr_pkg::*;
#(
  parameter int DATA_BITS       = 16,
  parameter int BURST_LENGTH    = 8,
  parameter int MAX_CAS_LATENCY = 16,
  parameter int TAG_BITS        = 4
) (
  input  logic               cpu_clock_i,
  input  logic               ctrl_reset_i,
  sddr_read_capture_if.slave bus
);
  localparam int                HALF      = half_burst_length(BURST_LENGTH);
  localparam int                WORD_BITS = BURST_LENGTH * DATA_BITS;
  localparam int                BEAT_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(HALF - 1);

  cap_state_e           state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TAG_BITS-1:0]  cur_tag_q, cur_tag_d;
  logic [WORD_BITS-1:0] asm_q, asm_d;
  logic                 rsp_ready_q, rsp_ready_d;
  logic [WORD_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_BITS-1:0]  rsp_tag_q, rsp_tag_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 range_err;
  logic                 overlap_err;
  logic                 start;
  logic                 pending;
  logic [TAG_BITS-1:0]  start_tag;

  sddr_read_latency_pipe #(
    .BURST_LENGTH    (BURST_LENGTH),
    .MAX_CAS_LATENCY (MAX_CAS_LATENCY),
    .TAG_BITS        (TAG_BITS)
  ) u_latency_pipe (
    .cpu_clock_i   (cpu_clock_i),
    .ctrl_reset_i  (ctrl_reset_i),
    .issue_i       (bus.read_issue_i),
    .tag_i         (bus.read_tag_i),
    .cas_latency_i (bus.cas_latency_i),
    .accept_o      (accept),
    .range_err_o   (range_err),
    .overlap_err_o (overlap_err),
    .start_o       (start),
    .start_tag_o   (start_tag),
    .pending_o     (pending)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cur_tag_d   = cur_tag_q;
    asm_d       = asm_q;
    rsp_ready_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    case (state_q)
      CAP_IDLE: begin
        if (start) begin
          state_d   = CAP_ACTIVE;
          beat_d    = '0;
          cur_tag_d = start_tag;
        end
      end
      CAP_ACTIVE: begin
        asm_d[beat_lsb(2 * int'(beat_q), DATA_BITS) +: DATA_BITS]     = bus.ddr3_dq_i[0];
        asm_d[beat_lsb(2 * int'(beat_q) + 1, DATA_BITS) +: DATA_BITS] = bus.ddr3_dq_i[1];
        if (beat_q == LAST_BEAT) begin
          rsp_ready_d = 1'b1;
          rsp_data_d  = asm_d;
          rsp_tag_d   = cur_tag_q;
          // A window starting right behind this one continues without a bubble.
          if (start) begin
            beat_d    = '0;
            cur_tag_d = start_tag;
          end else begin
            state_d = CAP_IDLE;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = CAP_IDLE;
    endcase
    err_d = (err_q && !bus.error_clear_i) || range_err || overlap_err;
  end

  always_ff @(posedge cpu_clock_i) begin
    if (ctrl_reset_i) begin
      state_q     <= CAP_IDLE;
      beat_q      <= '0;
      cur_tag_q   <= '0;
      asm_q       <= '0;
      rsp_ready_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cur_tag_q   <= cur_tag_d;
      asm_q       <= asm_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
    end
  end

  assign bus.data_rsp_ready_o = rsp_ready_q;
  assign bus.data_rsp_data_o  = rsp_data_q;
  assign bus.data_rsp_tag_o   = rsp_tag_q;
  assign bus.capture_busy_o   = pending || (state_q != CAP_IDLE) || accept;
  assign bus.protocol_error_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sddr_read_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sddr_read_capture: directed and randomized bench with window model. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sddr_read_capture;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sddr_read_capture_if #(.DATA_BITS(16), .BURST_LENGTH(8), .TAG_BITS(4)) bus ();

  sddr_read_capture #(
    .DATA_BITS (16), .BURST_LENGTH (8), .MAX_CAS_LATENCY (16), .TAG_BITS (4)
  ) dut (
    .cpu_clock_i  (clk),
    .ctrl_reset_i (rst),
    .bus          (bus)
  );

  typedef struct {
    int           issue;
    int           start;
    logic [3:0]   tag;
    logic [127:0] data;
  } rd_t;

  rd_t          q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           last_start = -1000;
  bit           m_ready = 0, m_err = 0, exp_busy = 0;
  logic [3:0]   m_tag  = '0;
  logic [127:0] m_data = '0;
  bit           p_rst = 1, p_ready = 0, p_err = 0;
  logic [3:0]   p_tag  = '0;
  logic [127:0] p_data = '0;

  // One clock: commit last cycle's model outcome, drive this cycle, predict, settle to negedge.
  task automatic tick(input bit r, input bit iss, input logic [3:0] tg, input logic [15:0] cl,
                      input logic [15:0] d0, input logic [15:0] d1, input bit clr);
    rd_t e;
    int  k;
    @(posedge clk);
    #1;
    if (p_rst) begin
      q.delete();
      m_ready = 0; m_data = '0; m_tag = '0; m_err = 0; last_start = -1000;
    end else begin
      m_ready = p_ready;
      if (p_ready) begin
        m_data = p_data; m_tag = p_tag;
        void'(q.pop_front());
      end
      m_err = p_err;
    end
    cyc++;
    rst = r;
    bus.read_issue_i = iss; bus.read_tag_i = tg; bus.cas_latency_i = cl;
    bus.ddr3_dq_i[0] = d0; bus.ddr3_dq_i[1] = d1; bus.error_clear_i = clr;
    p_rst = r; p_ready = 0; p_err = m_err && !clr;
    if (!r) begin
      if (iss) begin
        if (cl == 16'd0 || cl > 16'd16) p_err = 1;
        else if (cyc + int'(cl) < last_start + HALF) p_err = 1;
        else begin
          e.issue = cyc; e.start = cyc + int'(cl); e.tag = tg; e.data = '0;
          q.push_back(e);
          last_start = cyc + int'(cl);
        end
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (e.start <= cyc && cyc < e.start + HALF) begin
          k = cyc - e.start;
          e.data[(2 * k) * 16 +: 16]     = d0;
          e.data[(2 * k + 1) * 16 +: 16] = d1;
          q[i] = e;
        end
        if (e.start + HALF == cyc + 1) begin
          p_ready = 1; p_tag = e.tag; p_data = e.data;
        end
      end
    end
    exp_busy = 0;
    foreach (q[i]) if (q[i].issue <= cyc && cyc < q[i].start + HALF) exp_busy = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 4'h5, 16'd3, 16'h1234, 16'h5678, 0);
    n_tests++;
    if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o} !== 7'b0
        || bus.data_rsp_data_o !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%0b tag=%0h busy=%0b err=%0b data=%h, expected all zero",
               bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o,
               bus.data_rsp_data_o);
    end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.capture_busy_o !== 1'b0 || bus.data_rsp_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read_ignored: busy=%0b rdy=%0b, expected 0 0",
               bus.capture_busy_o, bus.data_rsp_ready_o);
    end
  endtask

  task automatic test_single();
    logic [127:0] want = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    for (int i = 0; i <= 11; i++) begin
      if (i >= 5 && i <= 8) tick(0, 0, 4'd3, 16'd5, 16'(2 * (i - 5) + 1), 16'(2 * (i - 5) + 2), 0);
      else tick(0, i == 0, 4'd3, 16'd5, 16'($urandom), 16'($urandom), 0);
      n_tests++;
      if (bus.data_rsp_ready_o !== (i == 9)) begin
        n_fail++;
        $display("FAIL single_ready i=%0d: got %0b expected %0b", i, bus.data_rsp_ready_o, i == 9);
      end
      if (i == 9) begin
        n_tests++;
        if (bus.data_rsp_data_o !== want || bus.data_rsp_tag_o !== 4'd3) begin
          n_fail++;
          $display("FAIL single_word: got %h tag %0h, expected %h tag 3",
                   bus.data_rsp_data_o, bus.data_rsp_tag_o, want);
        end
      end
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL single_model c%0d: got rdy=%0b tag=%0h busy=%0b err=%0b, expected %0b %0h %0b %0b",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o,
                 bus.protocol_error_o, m_ready, m_tag, exp_busy, m_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 16; i++) begin
      tick(0, i == 0 || i == 4, (i == 0) ? 4'd1 : 4'd2, 16'd6, 16'($urandom), 16'($urandom), i == 0);
      n_tests++;
      if (bus.capture_busy_o !== (i <= 13) || bus.data_rsp_ready_o !== (i == 10 || i == 14)) begin
        n_fail++;
        $display("FAIL b2b_timing i=%0d: busy=%0b rdy=%0b, expected %0b %0b", i,
                 bus.capture_busy_o, bus.data_rsp_ready_o, i <= 13, i == 10 || i == 14);
      end
      if (i >= 1 && bus.protocol_error_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_error i=%0d: got 1 expected 0", i);
      end
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL b2b_model c%0d: got rdy=%0b tag=%0h data=%h, expected %0b %0h %h",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.data_rsp_data_o,
                 m_ready, m_tag, m_data);
      end
    end
  endtask

  task automatic test_spacing();
    for (int i = 0; i <= 14; i++) begin
      tick(0, i == 0 || i == 2, (i == 0) ? 4'd5 : 4'd6, 16'd6, 16'($urandom), 16'($urandom),
           i == 0 || i == 13);
      n_tests++;
      if (bus.data_rsp_ready_o !== (i == 10) || bus.protocol_error_o !== (i >= 3 && i <= 13)) begin
        n_fail++;
        $display("FAIL spacing i=%0d: rdy=%0b err=%0b, expected %0b %0b", i,
                 bus.data_rsp_ready_o, bus.protocol_error_o, i == 10, i >= 3 && i <= 13);
      end
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL spacing_model c%0d: got rdy=%0b tag=%0h data=%h, expected %0b %0h %h",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.data_rsp_data_o,
                 m_ready, m_tag, m_data);
      end
    end
  endtask

  task automatic test_cl_range();
    logic [15:0] cls [3] = '{16'd0, 16'd17, 16'd16};
    for (int i = 0; i <= 23; i++) begin
      tick(0, i <= 2, 4'd7, (i <= 2) ? cls[i] : 16'd0, 16'($urandom), 16'($urandom), i == 23);
      n_tests++;
      if (bus.data_rsp_ready_o !== (i == 22) || bus.protocol_error_o !== (i >= 1)) begin
        n_fail++;
        $display("FAIL cl_range i=%0d: rdy=%0b err=%0b, expected %0b %0b", i,
                 bus.data_rsp_ready_o, bus.protocol_error_o, i == 22, i >= 1);
      end
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL cl_range_model c%0d: got rdy=%0b tag=%0h busy=%0b, expected %0b %0h %0b",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o,
                 m_ready, m_tag, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] want = '0;
    for (int i = 0; i <= 19; i++) begin
      tick(i == 4, i == 0 || i == 12, (i == 0) ? 4'hA : 4'h9, (i == 0) ? 16'd3 : 16'd2,
           16'h1000 + 16'(i), 16'h2000 + 16'(i), i == 0);
      if (i >= 14 && i <= 17) begin
        want[(2 * (i - 14)) * 16 +: 16]     = 16'h1000 + 16'(i);
        want[(2 * (i - 14) + 1) * 16 +: 16] = 16'h2000 + 16'(i);
      end
      n_tests++;
      if (bus.data_rsp_ready_o !== (i == 18)) begin
        n_fail++;
        $display("FAIL reset_mid_ready i=%0d: got %0b expected %0b", i, bus.data_rsp_ready_o, i == 18);
      end
      if (i >= 5 && i <= 11) begin
        n_tests++;
        if ({bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o} !== 6'b0
            || bus.data_rsp_data_o !== 128'b0) begin
          n_fail++;
          $display("FAIL reset_mid_idle i=%0d: tag=%0h busy=%0b err=%0b data=%h, expected zeros", i,
                   bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o, bus.data_rsp_data_o);
        end
      end
      if (i == 18) begin
        n_tests++;
        if (bus.data_rsp_data_o !== want || bus.data_rsp_tag_o !== 4'h9) begin
          n_fail++;
          $display("FAIL reset_mid_fresh: got %h tag %0h, expected %h tag 9",
                   bus.data_rsp_data_o, bus.data_rsp_tag_o, want);
        end
      end
    end
  endtask

  task automatic test_overtake();
    for (int i = 0; i <= 15; i++) begin
      tick(0, i <= 1, (i == 0) ? 4'hC : 4'hD, (i == 0) ? 16'd10 : 16'd4,
           16'($urandom), 16'($urandom), i == 0);
      n_tests++;
      if (bus.data_rsp_ready_o !== (i == 14) || bus.protocol_error_o !== (i >= 2)) begin
        n_fail++;
        $display("FAIL overtake i=%0d: rdy=%0b err=%0b, expected %0b %0b", i,
                 bus.data_rsp_ready_o, bus.protocol_error_o, i == 14, i >= 2);
      end
      if (i == 14 && bus.data_rsp_tag_o !== 4'hC) begin
        n_fail++;
        $display("FAIL overtake_tag: got %0h expected c", bus.data_rsp_tag_o);
      end
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL overtake_model c%0d: got rdy=%0b tag=%0h data=%h, expected %0b %0h %h",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.data_rsp_data_o,
                 m_ready, m_tag, m_data);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
           16'($urandom_range(0, 17)), 16'($urandom), 16'($urandom), $urandom_range(0, 24) == 0);
      n_tests++;
      if ({bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o, bus.protocol_error_o}
          !== {m_ready, m_tag, exp_busy, m_err} || bus.data_rsp_data_o !== m_data) begin
        n_fail++;
        $display("FAIL random_model c%0d: got rdy=%0b tag=%0h busy=%0b err=%0b data=%h, expected %0b %0h %0b %0b %h",
                 cyc, bus.data_rsp_ready_o, bus.data_rsp_tag_o, bus.capture_busy_o,
                 bus.protocol_error_o, bus.data_rsp_data_o, m_ready, m_tag, exp_busy, m_err, m_data);
      end
    end
  endtask

  initial begin
    bus.read_issue_i  = 1'b0;
    bus.read_tag_i    = '0;
    bus.cas_latency_i = '0;
    bus.ddr3_dq_i     = '0;
    bus.error_clear_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_spacing();
    test_cl_range();
    test_reset_mid();
    test_overtake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
